// File: rtl/trace_pkg.sv
// Shared record layout, compare mask indices and FSM encoding for the commit-trace checker.
package trace_pkg;

  localparam int unsigned REC_W      = 202;
  localparam int unsigned PC_LSB     = 0;
  localparam int unsigned INSTR_LSB  = 32;
  localparam int unsigned RADDR_LSB  = 64;
  localparam int unsigned RDATA_LSB  = 69;
  localparam int unsigned LD_BIT     = 101;
  localparam int unsigned ST_BIT     = 102;
  localparam int unsigned FP_BIT     = 103;
  localparam int unsigned SIZE_LSB   = 104;
  localparam int unsigned MADDR_LSB  = 106;
  localparam int unsigned MDATA_LSB  = 138;
  localparam int unsigned FFLAGS_LSB = 170;

  localparam int unsigned MASK_W  = 8;
  localparam int unsigned M_PC    = 0;
  localparam int unsigned M_INSTR = 1;
  localparam int unsigned M_RADDR = 2;
  localparam int unsigned M_RDATA = 3;
  localparam int unsigned M_MADDR = 4;
  localparam int unsigned M_MDATA = 5;
  localparam int unsigned M_FFLAG = 6;
  localparam int unsigned M_CLASS = 7;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DONE} state_e;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [31:0] pc, input logic [31:0] instr,
    input logic [4:0]  raddr, input logic [31:0] rdata,
    input logic ld, input logic st, input logic fp, input logic [1:0] size,
    input logic [31:0] maddr, input logic [31:0] mdata, input logic [31:0] fflags);
    logic [REC_W-1:0] r;
    r = '0;
    r[PC_LSB +: 32]     = pc;
    r[INSTR_LSB +: 32]  = instr;
    r[RADDR_LSB +: 5]   = raddr;
    r[RDATA_LSB +: 32]  = rdata;
    r[LD_BIT]           = ld;
    r[ST_BIT]           = st;
    r[FP_BIT]           = fp;
    r[SIZE_LSB +: 2]    = size;
    r[MADDR_LSB +: 32]  = maddr;
    r[MDATA_LSB +: 32]  = mdata;
    r[FFLAGS_LSB +: 32] = fflags;
    return r;
  endfunction

  // Store data lanes that are significant for a given access size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/trace_checker_if.sv
// Commit-trace bus as produced by the core's commit tracer.
interface trace_checker_if;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        is_load;
  logic        is_store;
  logic        is_float;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] fpu_flags;

  modport master (output valid, pc, instr, reg_addr, reg_data, is_load, is_store,
                  is_float, mem_size, mem_addr, mem_data, fpu_flags);
  modport slave  (input  valid, pc, instr, reg_addr, reg_data, is_load, is_store,
                  is_float, mem_size, mem_addr, mem_data, fpu_flags);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO; a push on a full FIFO is accepted when a pop happens on the same edge.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/trace_checker.sv
// Buffers DUT commits and golden expected records, compares them in order and reports divergences.
module trace_checker
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter bit          STOP_ON_MISMATCH = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  trace_checker_if.slave    cm,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [REC_W-1:0]  exp_rec_i,
  input  logic              exp_last_i,
  output logic [31:0]       match_cnt_o,
  output logic [31:0]       mismatch_cnt_o,
  output logic [31:0]       first_pc_o,
  output logic [MASK_W-1:0] first_mask_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic              error_o
);
  state_e            state_q, state_d;
  logic [31:0]       match_q, match_d, mism_q, mism_d, fpc_q, fpc_d;
  logic [MASK_W-1:0] fmask_q, fmask_d;
  logic              seen_q, seen_d, ovf_q, ovf_d, done_q, done_d, err_q, err_d;

  logic [REC_W-1:0]  c_push_rec, c_rec, e_rec;
  logic              c_full, c_empty, e_full, e_empty, e_last, pop;
  logic [MASK_W-1:0] mask;
  logic [31:0]       dmask;

  assign c_push_rec = pack_rec(cm.pc, cm.instr, cm.reg_addr, cm.reg_data, cm.is_load,
                               cm.is_store, cm.is_float, cm.mem_size, cm.mem_addr,
                               cm.mem_data, cm.fpu_flags);
  assign exp_ready_o = !e_full;

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_cmt_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(cm.valid), .data_i(c_push_rec),
    .pop_i(pop), .data_o(c_rec), .full_o(c_full), .empty_o(c_empty));

  trace_fifo #(.WIDTH(REC_W+1), .DEPTH(DEPTH)) u_exp_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(exp_valid_i && exp_ready_o),
    .data_i({exp_last_i, exp_rec_i}), .pop_i(pop), .data_o({e_last, e_rec}),
    .full_o(e_full), .empty_o(e_empty));

  // Field mask: which fields are relevant is decided by the expected record's class.
  always_comb begin
    mask  = '0;
    dmask = size_mask(e_rec[SIZE_LSB +: 2]);
    mask[M_PC]    = c_rec[PC_LSB +: 32] != e_rec[PC_LSB +: 32];
    mask[M_INSTR] = c_rec[INSTR_LSB +: 32] != e_rec[INSTR_LSB +: 32];
    mask[M_CLASS] = {c_rec[LD_BIT], c_rec[ST_BIT], c_rec[FP_BIT], c_rec[SIZE_LSB +: 2]} !=
                    {e_rec[LD_BIT], e_rec[ST_BIT], e_rec[FP_BIT], e_rec[SIZE_LSB +: 2]};
    if (e_rec[ST_BIT]) begin
      mask[M_MADDR] = c_rec[MADDR_LSB +: 32] != e_rec[MADDR_LSB +: 32];
      mask[M_MDATA] = ((c_rec[MDATA_LSB +: 32] ^ e_rec[MDATA_LSB +: 32]) & dmask) != 32'd0;
    end else begin
      if (e_rec[FP_BIT] || (e_rec[RADDR_LSB +: 5] != 5'd0)) begin
        mask[M_RADDR] = c_rec[RADDR_LSB +: 5] != e_rec[RADDR_LSB +: 5];
        mask[M_RDATA] = c_rec[RDATA_LSB +: 32] != e_rec[RDATA_LSB +: 32];
      end
      if (e_rec[FP_BIT]) mask[M_FFLAG] = c_rec[FFLAGS_LSB +: 32] != e_rec[FFLAGS_LSB +: 32];
      if (e_rec[LD_BIT]) mask[M_MADDR] = c_rec[MADDR_LSB +: 32] != e_rec[MADDR_LSB +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    mism_d  = mism_q;
    fpc_d   = fpc_q;
    fmask_d = fmask_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    err_d   = err_q;
    pop     = 1'b0;
    if (state_q == ST_RUN && !c_empty && !e_empty) begin
      pop = 1'b1;
      if (mask != '0) begin
        mism_d = (mism_q == 32'hFFFF_FFFF) ? mism_q : mism_q + 32'd1;
        err_d  = 1'b1;
        if (!seen_q) begin
          seen_d  = 1'b1;
          fpc_d   = c_rec[PC_LSB +: 32];
          fmask_d = mask;
        end
        if (STOP_ON_MISMATCH) state_d = ST_HALT;
      end else begin
        match_d = (match_q == 32'hFFFF_FFFF) ? match_q : match_q + 32'd1;
      end
      if (e_last) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
    // Commit dropped on a full FIFO; a HALTed checker no longer reports it.
    if (cm.valid && c_full && !pop && state_q != ST_HALT) begin
      ovf_d = 1'b1;
      err_d = 1'b1;
      if (state_q == ST_RUN) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      match_q <= '0;
      mism_q  <= '0;
      fpc_q   <= '0;
      fmask_q <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      fpc_q   <= fpc_d;
      fmask_q <= fmask_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign match_cnt_o    = match_q;
  assign mismatch_cnt_o = mism_q;
  assign first_pc_o     = fpc_q;
  assign first_mask_o   = fmask_q;
  assign overflow_o     = ovf_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: one halting and one free-running instance share all stimulus.
module tb_trace_checker;
  import trace_pkg::*;

  logic clk = 1'b0;
  logic reset_i;
  logic exp_valid_i, exp_last_i;
  logic [REC_W-1:0] exp_rec_i;
  int cmp_cnt = 0;
  int fail_cnt = 0;

  logic [31:0] s_match, s_mism, s_fpc, c_match, c_mism, c_fpc;
  logic [7:0]  s_fmask, c_fmask;
  logic        s_ovf, s_done, s_err, s_rdy, c_ovf, c_done, c_err, c_rdy;

  trace_checker_if cif();

  always #5 clk = ~clk;

  trace_checker #(.DEPTH(16), .STOP_ON_MISMATCH(1'b1)) dut_stop (
    .clk_i(clk), .reset_i(reset_i), .cm(cif.slave), .exp_valid_i(exp_valid_i),
    .exp_ready_o(s_rdy), .exp_rec_i(exp_rec_i), .exp_last_i(exp_last_i),
    .match_cnt_o(s_match), .mismatch_cnt_o(s_mism), .first_pc_o(s_fpc),
    .first_mask_o(s_fmask), .overflow_o(s_ovf), .done_o(s_done), .error_o(s_err));

  trace_checker #(.DEPTH(16), .STOP_ON_MISMATCH(1'b0)) dut_cont (
    .clk_i(clk), .reset_i(reset_i), .cm(cif.slave), .exp_valid_i(exp_valid_i),
    .exp_ready_o(c_rdy), .exp_rec_i(exp_rec_i), .exp_last_i(exp_last_i),
    .match_cnt_o(c_match), .mismatch_cnt_o(c_mism), .first_pc_o(c_fpc),
    .first_mask_o(c_fmask), .overflow_o(c_ovf), .done_o(c_done), .error_o(c_err));

  function automatic logic [REC_W-1:0] int_rec(input logic [31:0] pc, input logic [31:0] instr,
                                               input logic [4:0] rd, input logic [31:0] data);
    return pack_rec(pc, instr, rd, data, 1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 32'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One cycle of stimulus: optional commit and optional expected record.
  task automatic drive(input logic cv, input logic [REC_W-1:0] crec,
                       input logic ev, input logic [REC_W-1:0] erec, input logic el);
    cif.valid     = cv;
    cif.pc        = crec[PC_LSB +: 32];
    cif.instr     = crec[INSTR_LSB +: 32];
    cif.reg_addr  = crec[RADDR_LSB +: 5];
    cif.reg_data  = crec[RDATA_LSB +: 32];
    cif.is_load   = crec[LD_BIT];
    cif.is_store  = crec[ST_BIT];
    cif.is_float  = crec[FP_BIT];
    cif.mem_size  = crec[SIZE_LSB +: 2];
    cif.mem_addr  = crec[MADDR_LSB +: 32];
    cif.mem_data  = crec[MDATA_LSB +: 32];
    cif.fpu_flags = crec[FFLAGS_LSB +: 32];
    exp_valid_i   = ev;
    exp_rec_i     = erec;
    exp_last_i    = el;
    tick();
    cif.valid   = 1'b0;
    exp_valid_i = 1'b0;
    exp_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    cif.valid = 1'b0; exp_valid_i = 1'b0; exp_last_i = 1'b0; exp_rec_i = '0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++;
    if ({s_match, s_mism, s_fpc, s_fmask, s_ovf, s_done, s_err} !== 107'd0) begin
      fail_cnt++; $display("FAIL reset.outs got %0d/%0d/%h/%h/%b%b%b want zeros", s_match, s_mism, s_fpc, s_fmask, s_ovf, s_done, s_err);
    end
    cmp_cnt++;
    if (s_rdy !== 1'b1 || c_rdy !== 1'b1) begin
      fail_cnt++; $display("FAIL reset.ready got %b%b want 11", s_rdy, c_rdy);
    end
  endtask

  task automatic test_match4();
    logic [REC_W-1:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r = int_rec(32'h8000_0000 + 32'(4*i), 32'h0100_0293, 5'd5, 32'h0000_0010);
      drive(1'b1, r, 1'b1, r, i == 3);
    end
    idle(3);
    cmp_cnt++;
    if (s_match !== 32'd4 || c_match !== 32'd4) begin
      fail_cnt++; $display("FAIL match4.match got %0d/%0d want 4", s_match, c_match);
    end
    cmp_cnt++;
    if (s_mism !== 32'd0) begin fail_cnt++; $display("FAIL match4.mism got %0d want 0", s_mism); end
    cmp_cnt++;
    if (s_done !== 1'b1 || s_err !== 1'b0) begin
      fail_cnt++; $display("FAIL match4.flags got done=%b err=%b want done=1 err=0", s_done, s_err);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1'b1, int_rec(32'h8000_0040, 32'h0000_0013, 5'd0, 32'h0000_1234),
          1'b1, int_rec(32'h8000_0040, 32'h0000_0013, 5'd0, 32'h0000_0000), 1'b1);
    idle(2);
    cmp_cnt++;
    if (s_match !== 32'd1 || s_mism !== 32'd0 || s_done !== 1'b1) begin
      fail_cnt++; $display("FAIL x0.ignore got match=%0d mism=%0d done=%b want 1/0/1", s_match, s_mism, s_done);
    end
  endtask

  task automatic test_store();
    do_reset();
    drive(1'b1, pack_rec(32'h8000_0100, 32'h00b5_0023, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h8000_1000, 32'hAABB_CC11, 32'd0),
          1'b1, pack_rec(32'h8000_0100, 32'h00b5_0023, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h8000_1000, 32'h0000_0011, 32'd0), 1'b0);
    idle(2);
    cmp_cnt++;
    if (s_match !== 32'd1 || s_err !== 1'b0) begin
      fail_cnt++; $display("FAIL store.byte_match got match=%0d err=%b want 1/0", s_match, s_err);
    end
    drive(1'b1, pack_rec(32'h8000_0104, 32'h00b5_0023, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h8000_1000, 32'hAABB_CC11, 32'd0),
          1'b1, pack_rec(32'h8000_0104, 32'h00b5_0023, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h8000_1000, 32'h0000_0022, 32'd0), 1'b1);
    idle(2);
    cmp_cnt++;
    if (s_fmask !== 8'h20) begin fail_cnt++; $display("FAIL store.mask got %h want 20", s_fmask); end
    cmp_cnt++;
    if (s_fpc !== 32'h8000_0104) begin fail_cnt++; $display("FAIL store.pc got %h want 80000104", s_fpc); end
    cmp_cnt++;
    if (s_err !== 1'b1 || s_mism !== 32'd1) begin
      fail_cnt++; $display("FAIL store.err got err=%b mism=%0d want 1/1", s_err, s_mism);
    end
  endtask

  task automatic test_stop();
    logic [REC_W-1:0] cr, er;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cr = int_rec(32'h8000_0300 + 32'(4*i), 32'h0000_0093, 5'd1, 32'(i));
      er = cr;
      if (i == 1) er = int_rec(32'h8000_0300 + 32'(4*i), 32'h0010_0093, 5'd1, 32'(i));
      drive(1'b1, cr, 1'b1, er, i == 4);
    end
    idle(3);
    cmp_cnt++;
    if (s_match !== 32'd1 || s_mism !== 32'd1 || s_done !== 1'b0) begin
      fail_cnt++; $display("FAIL stop.halt got match=%0d mism=%0d done=%b want 1/1/0", s_match, s_mism, s_done);
    end
    cmp_cnt++;
    if (c_match !== 32'd4 || c_mism !== 32'd1 || c_done !== 1'b1) begin
      fail_cnt++; $display("FAIL stop.cont got match=%0d mism=%0d done=%b want 4/1/1", c_match, c_mism, c_done);
    end
    cmp_cnt++;
    if (s_fmask !== 8'h02 || c_fpc !== 32'h8000_0304) begin
      fail_cnt++; $display("FAIL stop.first got mask=%h pc=%h want 02/80000304", s_fmask, c_fpc);
    end
  endtask

  task automatic test_overflow();
    logic [REC_W-1:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      r = int_rec(32'h8000_0400 + 32'(4*i), 32'h0000_0013, 5'd0, 32'd0);
      drive(1'b1, r, 1'b0, '0, 1'b0);
    end
    cmp_cnt++;
    if (s_ovf !== 1'b0) begin fail_cnt++; $display("FAIL ovf.at_depth got %b want 0", s_ovf); end
    drive(1'b1, int_rec(32'h8000_0440, 32'h0000_0013, 5'd0, 32'd0), 1'b0, '0, 1'b0);
    cmp_cnt++;
    if (s_ovf !== 1'b1 || s_err !== 1'b1 || c_ovf !== 1'b1) begin
      fail_cnt++; $display("FAIL ovf.set got ovf=%b err=%b cont_ovf=%b want 1/1/1", s_ovf, s_err, c_ovf);
    end
    drive(1'b0, '0, 1'b1, int_rec(32'h8000_0400, 32'h0000_0013, 5'd0, 32'd0), 1'b0);
    idle(3);
    cmp_cnt++;
    if (s_match !== 32'd0 || s_mism !== 32'd0) begin
      fail_cnt++; $display("FAIL ovf.halted got match=%0d mism=%0d want 0/0", s_match, s_mism);
    end
  endtask

  task automatic test_float();
    do_reset();
    drive(1'b1, pack_rec(32'h8000_0200, 32'h0010_7153, 5'd3, 32'h3f80_0000, 1'b0, 1'b0, 1'b1, 2'b10, 32'd0, 32'd0, 32'd1),
          1'b1, pack_rec(32'h8000_0200, 32'h0010_7153, 5'd3, 32'h3f80_0000, 1'b0, 1'b0, 1'b1, 2'b10, 32'd0, 32'd0, 32'd0), 1'b1);
    idle(2);
    cmp_cnt++;
    if (s_fmask !== 8'h40 || s_mism !== 32'd1) begin
      fail_cnt++; $display("FAIL float.fflags got mask=%h mism=%0d want 40/1", s_fmask, s_mism);
    end
  endtask

  task automatic test_reset_mid();
    logic [REC_W-1:0] r;
    do_reset();
    drive(1'b1, int_rec(32'h8000_0500, 32'h0000_0093, 5'd1, 32'd1),
          1'b1, int_rec(32'h8000_0500, 32'h0000_0093, 5'd1, 32'd2), 1'b0);
    r = int_rec(32'h8000_0504, 32'h0000_0093, 5'd1, 32'd5);
    drive(1'b1, r, 1'b0, '0, 1'b0);
    drive(1'b1, r, 1'b0, '0, 1'b0);
    cmp_cnt++;
    if (s_mism !== 32'd1 || s_err !== 1'b1) begin
      fail_cnt++; $display("FAIL midrst.pre got mism=%0d err=%b want 1/1", s_mism, s_err);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    cmp_cnt++;
    if ({s_match, s_mism, s_fpc, s_fmask, s_ovf, s_done, s_err} !== 107'd0 || s_rdy !== 1'b1) begin
      fail_cnt++; $display("FAIL midrst.outs got %0d/%0d/%h/%h/%b%b%b rdy=%b want zeros rdy=1", s_match, s_mism, s_fpc, s_fmask, s_ovf, s_done, s_err, s_rdy);
    end
    drive(1'b0, '0, 1'b1, r, 1'b0);
    idle(3);
    cmp_cnt++;
    if (s_match !== 32'd0 || s_mism !== 32'd0 || c_match !== 32'd0) begin
      fail_cnt++; $display("FAIL midrst.flushed got match=%0d mism=%0d want 0/0", s_match, s_mism);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    cif.valid = 1'b0;
    exp_valid_i = 1'b0;
    exp_last_i = 1'b0;
    exp_rec_i = '0;
    idle(2);
    test_reset();
    test_match4();
    test_x0();
    test_store();
    test_stop();
    test_overflow();
    test_float();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
